// File: rtl/xalu_pkg.sv
// Shared definitions for the extended ALU bus initiator: op codes, register
// offsets, FSM states and the operand-usage decode.
package xalu_pkg;

    localparam logic [3:0] OP_A0   = 4'd0;
    localparam logic [3:0] OP_A1   = 4'd1;
    localparam logic [3:0] OP_SHR  = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_NOT  = 4'd9;
    localparam logic [3:0] OP_MAX  = OP_NOT;

    localparam logic [7:0] A0_OFS = 8'd0;
    localparam logic [7:0] A1_OFS = 8'd1;

    typedef enum logic [2:0] {
        IDLE,
        WR_A0,
        WR_A1,
        RD,
        RESP
    } state_t;

    function automatic logic uses_a0(input logic [3:0] op);
        return (op == OP_A0) || ((op >= OP_SHR) && (op <= OP_NOT));
    endfunction

    function automatic logic uses_a1(input logic [3:0] op);
        return (op == OP_A1) || ((op >= OP_AND) && (op <= OP_XOR));
    endfunction

endpackage

// File: rtl/xalu_master.sv
// Bus initiator for the extended ALU peripheral: writes operands (skipping
// writes that match the shadow copies), reads the op result and returns it.
module xalu_master
    import xalu_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'h0F,
    parameter int         DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic                  inval,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic [7:0]            bus_addr,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    state_t                state;
    state_t                next_state;
    logic [3:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic                  need_w1_q;
    logic [DATA_WIDTH-1:0] shadow0;
    logic [DATA_WIDTH-1:0] shadow1;
    logic                  valid0;
    logic                  valid1;
    logic                  accept;
    logic                  need_w0;
    logic                  need_w1;

    assign accept  = req_valid && (state == IDLE);
    assign need_w0 = uses_a0(req_op) && (!valid0 || (shadow0 != req_a));
    assign need_w1 = uses_a1(req_op) && (!valid1 || (shadow1 != req_b));

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        bus_addr   = 8'h00;
        bus_we     = 1'b0;
        bus_wdata  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_op > OP_MAX)
                        next_state = RESP;
                    else if (need_w0)
                        next_state = WR_A0;
                    else if (need_w1)
                        next_state = WR_A1;
                    else
                        next_state = RD;
                end
            end
            WR_A0: begin
                bus_addr   = BASE_ADDR + A0_OFS;
                bus_we     = 1'b1;
                bus_wdata  = a_q;
                next_state = need_w1_q ? WR_A1 : RD;
            end
            WR_A1: begin
                bus_addr   = BASE_ADDR + A1_OFS;
                bus_we     = 1'b1;
                bus_wdata  = b_q;
                next_state = RD;
            end
            RD: begin
                bus_addr   = BASE_ADDR + {4'h0, op_q};
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The A1 write decision is frozen at accept so a later inval cannot
    // change the shape of an op already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            need_w1_q <= 1'b0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                op_q      <= req_op;
                a_q       <= req_a;
                b_q       <= req_b;
                need_w1_q <= need_w1;
                if (req_op > OP_MAX) begin
                    resp_data <= '0;
                    resp_err  <= 1'b1;
                end
            end
            if (state == RD) begin
                resp_data <= bus_rdata;
                resp_err  <= 1'b0;
            end
        end
    end

    // Shadow copies of the peripheral operand registers; inval beats a
    // simultaneous write so an external writer is never masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow0 <= '0;
            shadow1 <= '0;
            valid0  <= 1'b0;
            valid1  <= 1'b0;
        end else begin
            if (state == WR_A0)
                shadow0 <= a_q;
            if (state == WR_A1)
                shadow1 <= b_q;
            if (inval) begin
                valid0 <= 1'b0;
                valid1 <= 1'b0;
            end else begin
                if (state == WR_A0)
                    valid0 <= 1'b1;
                if (state == WR_A1)
                    valid1 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xalu_master.sv
// Self-checking bench for xalu_master with a behavioural ALU peripheral and
// a transaction-level model of the operand shadows.
module tb_xalu_master;

    localparam logic [7:0] BASE = 8'h0F;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       inval;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_err;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Transaction-level model state: what the peripheral operands are known to hold
    bit         mv0;
    bit         mv1;
    logic [7:0] ms0;
    logic [7:0] ms1;

    xalu_master #(
        .BASE_ADDR (BASE),
        .DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .inval     (inval),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_err  (resp_err),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_result(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        case (op)
            4'd0:    return a;
            4'd1:    return b;
            4'd2:    return {1'b0, a[7:1]};
            4'd3:    return {a[6:0], 1'b0};
            4'd4:    return a & b;
            4'd5:    return ~(a & b);
            4'd6:    return a | b;
            4'd7:    return ~(a | b);
            4'd8:    return a ^ b;
            4'd9:    return ~a;
            default: return 8'h00;
        endcase
    endfunction

    // Behavioural ALU peripheral: registered operands, combinational results
    logic [7:0] p_a0 = 8'h00;
    logic [7:0] p_a1 = 8'h00;
    logic [7:0] p_ofs;
    assign p_ofs     = bus_addr - BASE;
    assign bus_rdata = (p_ofs <= 8'd9) ? ref_result(p_ofs[3:0], p_a0, p_a1) : 8'h00;

    always @(posedge clk) begin
        if (bus_we && bus_addr == BASE)
            p_a0 <= bus_wdata;
        else if (bus_we && bus_addr == BASE + 8'd1)
            p_a1 <= bus_wdata;
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        inval     = 1'b0;
        @(negedge clk);
        check_output("rst_req_ready", req_ready, 1);
        check_output("rst_resp_valid", resp_valid, 0);
        check_output("rst_resp_data", resp_data, 0);
        check_output("rst_resp_err", resp_err, 0);
        check_output("rst_bus", {bus_we, bus_addr, bus_wdata}, 0);
        rst = 1'b0;
        mv0 = 0;
        mv1 = 0;
    endtask

    // One complete request/response transaction, with expectations from the model
    task automatic apply_stimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input int hold_cycles, input bit inv_during,
                                  output logic [7:0] got_data, output bit got_err,
                                  output int got_lat);
        int         waited = 0;
        int         lat;
        int         nwr = 0;
        bit         legal;
        bit         w0;
        bit         w1;
        logic [7:0] rd_addr = 8'h00;
        logic [7:0] exp_rd;
        logic [15:0] exp_wr[$];

        @(negedge clk);
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_output("req_ready_idle", req_ready, 1);

        legal = (op <= 4'd9);
        w0 = legal && (op != 4'd1) && (!mv0 || ms0 != a);
        w1 = legal && (op == 4'd1 || (op >= 4'd4 && op <= 4'd8)) && (!mv1 || ms1 != b);
        if (w0) exp_wr.push_back({BASE, a});
        if (w1) exp_wr.push_back({BASE + 8'd1, b});
        exp_rd = legal ? BASE + {4'h0, op} : 8'h00;

        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        inval     = inv_during;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);

        lat = 1;
        while (!resp_valid && lat < 8) begin
            if (bus_we) begin
                if (nwr < exp_wr.size())
                    check_output("bus_write", {bus_addr, bus_wdata}, exp_wr[nwr]);
                nwr++;
            end else if (bus_addr != 8'h00) begin
                rd_addr = bus_addr;
            end
            @(negedge clk);
            lat++;
        end
        inval = 1'b0;

        check_output("write_count", nwr, exp_wr.size());
        check_output("read_addr", rd_addr, exp_rd);
        check_output("latency", lat, legal ? 2 + int'(w0) + int'(w1) : 1);
        check_output("resp_data", resp_data, legal ? ref_result(op, a, b) : 8'h00);
        check_output("resp_err", resp_err, !legal);
        got_data = resp_data;
        got_err  = resp_err;
        got_lat  = lat;

        if (w0) begin mv0 = 1; ms0 = a; end
        if (w1) begin mv1 = 1; ms1 = b; end
        if (inv_during) begin mv0 = 0; mv1 = 0; end

        for (int k = 0; k < hold_cycles; k++) begin
            @(negedge clk);
            check_output("hold_valid", resp_valid, 1);
            check_output("hold_data", {resp_err, resp_data}, {got_err, got_data});
            check_output("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_output("resp_released", resp_valid, 0);
        check_output("ready_after_resp", req_ready, 1);
    endtask

    typedef struct {
        bit         rst_before;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         hold_cycles;
        logic [7:0] exp_data;
        bit         exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] d;
        bit         e;
        int         l;
        int         waited;

        vecs[0] = '{1'b1, 4'd4,  8'hF0, 8'h3C, 0, 8'h30, 1'b0, 4};
        vecs[1] = '{1'b0, 4'd8,  8'hF0, 8'h3C, 0, 8'hCC, 1'b0, 2};
        vecs[2] = '{1'b1, 4'd3,  8'h81, 8'h00, 0, 8'h02, 1'b0, 3};
        vecs[3] = '{1'b0, 4'd6,  8'h81, 8'h0F, 3, 8'h8F, 1'b0, 3};
        vecs[4] = '{1'b0, 4'd12, 8'h55, 8'hAA, 0, 8'h00, 1'b1, 1};
        vecs[5] = '{1'b0, 4'd9,  8'h81, 8'h0F, 0, 8'h7E, 1'b0, 2};
        vecs[6] = '{1'b0, 4'd1,  8'h81, 8'h0F, 0, 8'h0F, 1'b0, 2};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 4'd0;
        req_a      = 8'h00;
        req_b      = 8'h00;
        inval      = 1'b0;
        resp_ready = 1'b0;
        do_reset();

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold_cycles, 1'b0, d, e, l);
            check_output($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            check_output($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
            check_output($sformatf("vec%0d_lat", i), l, vecs[i].exp_lat);
        end

        // Reset while A1 is being written: op aborted, next identical op rewrites both
        do_reset();
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd4;
        req_a     = 8'hF0;
        req_b     = 8'h3C;
        @(negedge clk);
        req_valid = 1'b0;
        waited = 0;
        while (!(bus_we && bus_addr == BASE + 8'd1) && waited < 6) begin
            @(negedge clk);
            waited++;
        end
        check_output("abort_saw_wr_a1", bus_we && bus_addr == BASE + 8'd1, 1);
        rst = 1'b1;
        @(negedge clk);
        check_output("abort_we_dropped", bus_we, 0);
        check_output("abort_no_resp", resp_valid, 0);
        rst = 1'b0;
        mv0 = 0;
        mv1 = 0;
        waited = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) waited++;
        end
        check_output("abort_stays_quiet", waited, 0);
        apply_stimulus(4'd4, 8'hF0, 8'h3C, 0, 1'b0, d, e, l);
        check_output("abort_retry_lat", l, 4);

        // Inval between two identical ANDs forces both operands to be rewritten
        apply_stimulus(4'd4, 8'hF0, 8'h3C, 0, 1'b0, d, e, l);
        check_output("warm_and_lat", l, 2);
        @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        mv0 = 0;
        mv1 = 0;
        apply_stimulus(4'd4, 8'hF0, 8'h3C, 0, 1'b0, d, e, l);
        check_output("inval_and_lat", l, 4);
        check_output("inval_and_data", d, 8'h30);

        // Randomized traffic with a biased operand pool so shadow hits are common
        for (int i = 0; i < 150; i++) begin
            logic [3:0] op;
            logic [7:0] a;
            logic [7:0] b;
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 1) == 1) ? 8'h5A : 8'($urandom);
            b  = ($urandom_range(0, 1) == 1) ? 8'hC3 : 8'($urandom);
            if ($urandom_range(0, 39) == 0) do_reset();
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                inval = 1'b1;
                @(negedge clk);
                inval = 1'b0;
                mv0 = 0;
                mv1 = 0;
            end
            apply_stimulus(op, a, b, $urandom_range(0, 2), $urandom_range(0, 7) == 0, d, e, l);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/xalu_master.md
# xalu_master

Bus initiator for the extended ALU peripheral. It accepts an operation request (op code plus two operands) on a valid/ready port. It then runs the required write/read cycles on the 8-bit memory-mapped bus (addr, write enable, write data, combinational read data) and returns the peripheral's result on a valid/ready response port. It holds shadow copies of the two operand registers and skips bus writes that would not change them. It sits between the CPU control unit and the ALU peripheral and is the only writer of the peripheral's operand registers.

## Interface
- BASE_ADDR, 8'h0F: bus address of operand register A0. A1 is at BASE+1; op results are at BASE+op.
- data_width, 8: operand and result width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_op  in  4  peripheral op code: 0 A0, 1 A1, 2 SHR, 3 SHL, 4 AND, 5 NAND, 6 OR, 7 NOR, 8 XOR, 9 NOT.
- req_a, req_b  in  data_width  operands for A0 and A1.
- inval  in  1  invalidates both shadows (use after any external write to the peripheral).
- resp_valid  out  1  result present; held until accepted.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  data_width  result.
- resp_err  out  1  illegal op code (>9).
- bus_addr  out  8  bus address.
- bus_we  out  1  bus write strobe.
- bus_wdata  out  data_width  bus write data.
- bus_rdata  in  data_width  combinational read data from the peripheral.

## Operation
- States: IDLE, WR_A0, WR_A1, RD, RESP.
- On accept (req_valid && req_ready), latch op, a and b.
- Op uses A0 when op ∈ {0,2..9}. Op uses A1 when op ∈ {1,4..8}.
- IDLE exits on accept:
  - op>9: go to RESP with err=1, data=0, no bus activity.
  - Else go to WR_A0 if the op uses A0 and the A0 shadow is invalid or differs from a.
  - Else go to WR_A1 if the op uses A1 and the A1 shadow is invalid or differs from b.
  - Else go to RD.
- WR_A0: bus_addr=BASE, bus_we=1, bus_wdata=a. Shadow0 <= a, valid0 <= 1. Next state follows the same WR_A1/RD rule as IDLE.
- WR_A1: bus_addr=BASE+1, bus_we=1, bus_wdata=b. Shadow1 <= b, valid1 <= 1. Next state is RD.
- RD: bus_addr=BASE+op (8-bit add, wraps mod 256), bus_we=0. Capture bus_rdata into resp_data at the edge, err=0. Next state is RESP.
- RESP: resp_valid=1. resp_data and resp_err are stable until resp_valid && resp_ready, then go to IDLE.
- Bus outputs are decoded from the state and latched request. Outside write/read states: bus_addr=0x00, bus_we=0, bus_wdata=0.
- inval clears valid0 and valid1 at the next edge.
  - If inval coincides with a shadow write, inval wins.
  - An in-flight op is unaffected; its write decisions are already made.
- Request inputs are ignored unless the request is accepted.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, bus_we=0, bus_addr=0, bus_wdata=0, valid0=valid1=0.
- Reset mid-operation aborts the op. It drops bus_we in the cycle after the reset edge, and no response is produced.
- Latency from the accept edge to resp_valid high:
  - 4 cycles with both writes.
  - 3 cycles with one write.
  - 2 cycles with no writes.
  - 1 cycle for an illegal op.
- Throughput: the next accept is at the earliest one cycle after the response handshake, because req_ready is low in RESP.
- The peripheral registers a write at the edge that ends WR_*. RD is always at least one cycle after the last write, so bus_rdata reflects the new operands.

## Structure
- Shared package xalu_pkg holds:
  - Op-code localparams (OP_A0..OP_NOT, OP_MAX=9).
  - The state enum.
  - Offsets A0_OFS=0 and A1_OFS=1.
  - The uses_a0/uses_a1 decode functions.
- Single module; no sub-module is warranted. The shadow registers are a few flops inside.

## Test plan
- Cold AND, BASE=0x0F, a=0xF0, b=0x3C, paired with the ALU peripheral:
  - Cycle +1: addr 0x0F, we=1, wdata 0xF0.
  - Cycle +2: addr 0x10, we=1, wdata 0x3C.
  - Cycle +3: addr 0x13 read.
  - Cycle +4: resp_valid, data 0x30, err 0.
- Then XOR with the same operands: no bus writes, a single read at 0x17, resp 0xCC at +2.
- SHL a=0x81 after reset: only the A0 write (0x0F/0x81), read at 0x12, resp 0x02 at +3. A following OR a=0x81, b=0x0F writes only A1 and returns 0x8F.
- Op 12: resp_err=1, data 0x00 at +1, bus_we never asserted.
- resp_ready held low for 3 cycles in RESP: resp_valid, data and err stay constant and req_ready stays 0. Accept occurs in the cycle resp_ready rises.
- Mid-operation aborts:
  - rst asserted during WR_A1: bus_we=0 and resp_valid=0 afterwards. The next identical request performs both writes.
  - inval pulsed between two identical ANDs: the second AND rewrites both operands.
